// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the F/D/E/M/W core: stalls, flushes, operand forwarding and the
// multi-cycle execute hold FSM. Define HAZARD_PERF_EN to add StallCnt/FlushCnt event counters.
module hazard_ctrl #(
   parameter int unsigned EX_LAT = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             MemtoRegE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             BranchTakenE,
   input  logic             MulStartE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ExBusy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]      StallCnt,
   output logic [31:0]      FlushCnt
`endif
);

   typedef enum logic {Run, ExWait} state_e;

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(EX_LAT - 1);

   state_e           stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             ldrStall, pcPend;

   // R15 is the PC, not a bypassable register.
   function automatic logic [1:0] fwdSel(input logic [3:0] ra, input logic rwM,
                                         input logic [3:0] waM, input logic rwW,
                                         input logic [3:0] waW);
      logic [1:0] sel;
      sel = 2'b00;
      if (ra != 4'hF) begin
         if (rwM && (waM == ra)) begin
            sel = 2'b10;
         end else if (rwW && (waW == ra)) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   assign ldrStall = MemtoRegE && (WA3E != 4'hF) && ((WA3E == RA1D) || (WA3E == RA2D));
   assign pcPend   = PCSrcD || PCSrcE || PCSrcM;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stateQ <= Run;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ExBusy    = 1'b0;
      ForwardAE = fwdSel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwdSel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      unique case (stateQ)
         Run: begin
            StallF = ldrStall || pcPend;
            StallD = ldrStall;
            FlushD = pcPend || BranchTakenE;
            FlushE = ldrStall || BranchTakenE;
            // A taken branch squashes the op entering E, so no hold.
            if (MulStartE && !BranchTakenE) begin
               stateD = ExWait;
               cntD   = CntLoad;
            end
         end
         ExWait: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            ExBusy = 1'b1;
            if (cntQ != '0) begin
               cntD = cntQ - 1'b1;
            end
            if (cntQ <= CNT_W'(1)) begin
               stateD = Run;
               cntD   = '0;
            end
         end
         default: begin
            stateD = Run;
            cntD   = '0;
         end
      endcase
      if (!sys_rst_n) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         StallE    = 1'b0;
         FlushD    = 1'b0;
         FlushE    = 1'b0;
         FlushM    = 1'b0;
         ExBusy    = 1'b0;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (StallF && (StallCnt != '1)) begin
            StallCnt <= StallCnt + 32'd1;
         end
         if ((FlushD || FlushE || FlushM) && (FlushCnt != '1)) begin
            FlushCnt <= FlushCnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core (F/D/E/M/W); generates all stall, flush and forwarding controls.
- Consumes the condition-qualified execute signals (BranchTakenE, PCSrc, gated multi-cycle start) produced in E.
- Owns a small FSM that holds the pipeline while a multi-cycle execute unit (multiplier) occupies E.

Parameters:
EX_LAT, 4, total E-stage occupancy in cycles of a multi-cycle op; legal 2..16
CNT_W, 4, width of the busy down-counter; must satisfy 2^CNT_W > EX_LAT

Ports:
sys_clk  input  1  core clock, all state on rising edge
sys_rst_n  input  1  asynchronous active-low reset
RA1D  input  4  source reg 1 of instruction in D
RA2D  input  4  source reg 2 of instruction in D
RA1E  input  4  source reg 1 of instruction in E
RA2E  input  4  source reg 2 of instruction in E
WA3E  input  4  dest reg in E
WA3M  input  4  dest reg in M
WA3W  input  4  dest reg in W
MemtoRegE  input  1  load in E
RegWriteM  input  1  condition-qualified reg write in M
RegWriteW  input  1  reg write in W
PCSrcD  input  1  instruction in D writes R15
PCSrcE  input  1  condition-qualified R15 write in E
PCSrcM  input  1  R15 write in M
BranchTakenE  input  1  condition-qualified branch taken in E
MulStartE  input  1  condition-qualified multi-cycle op entering E
StallF  output  1  hold PC register
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register
FlushM  output  1  clear E/M register (bubble behind held E)
ForwardAE  output  2  operand A select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  operand B select, same encoding
ExBusy  output  1  high while FSM in EXWAIT

Behaviour:
- Reset (sys_rst_n low, async): state=RUN, cnt=0; all outputs forced 0 regardless of inputs while reset held.
- Forwarding (combinational): ForwardAE=10 if RegWriteM & WA3M==RA1E; else 01 if RegWriteW & WA3W==RA1E; else 00. M beats W. R15 (4'hF) never forwarded. Same for B with RA2E.
- ldrstall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D), R15 excluded.
- pcpend = PCSrcD | PCSrcE | PCSrcM.
- FSM states: RUN, EXWAIT.
- RUN: StallF = ldrstall | pcpend; StallD = ldrstall; FlushD = pcpend | BranchTakenE; FlushE = ldrstall | BranchTakenE; StallE=0, FlushM=0.
- RUN -> EXWAIT when MulStartE & ~BranchTakenE; cnt loaded EX_LAT-1. MulStartE with BranchTakenE same cycle: branch wins, no EXWAIT entry.
- EXWAIT: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0, ExBusy=1; ldrstall/pcpend/BranchTakenE ignored (E frozen, inputs stale). cnt decrements each cycle; at cnt==1 next state RUN, cnt=0. EXWAIT spans exactly EX_LAT-1 cycles; op leaves E on the following edge (total E occupancy EX_LAT).
- Only one multi-cycle op in flight; MulStartE during EXWAIT is ignored.
- Reset asserted mid-EXWAIT: immediate return to RUN, cnt=0, outputs 0.
- Counter never wraps: decrement gated at 0.

Optional Feature:
- Macro HAZARD_PERF_EN. Defined: adds outputs StallCnt[31:0] (increments each cycle StallF=1) and FlushCnt[31:0] (increments each cycle FlushD|FlushE|FlushM); both reset to 0, saturate at 32'hFFFF_FFFF. Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Forward priority: RegWriteM=1,WA3M=3; RegWriteW=1,WA3W=3; RA1E=3 -> ForwardAE=10; drop RegWriteM -> 01; RA1E=15 with matches -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle; next cycle MemtoRegE=0 -> all 0.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1, no stalls, state stays RUN.
- Multi-cycle EX_LAT=4: MulStartE pulse -> ExBusy, StallF/D/E, FlushM high exactly 3 cycles, then RUN; second MulStartE during busy ignored.
- Simultaneous MulStartE & BranchTakenE -> flushes only, ExBusy stays 0; reset pulse during EXWAIT -> outputs 0 immediately, RUN after release.
- HAZARD_PERF_EN: run load-use + 4-cycle mul sequence -> StallCnt=4, FlushCnt=4.
